ram_port_steer: RTL and testbench



---
 rtl/ram_port_steer.sv | 193 +++++++++++++++++++
 tb/tb_ram_port_steer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_steer.sv
// ram_port_steer: byte-lane steering front end for the split even/odd RAM.
//
// One 8- or 16-bit access is accepted at a time. The byte at address A goes
// to lane A[0] (0 = even, 1 = odd). The second byte of a wide access is at
// A+1 mod 2^15 and always uses the other lane. Read data is assembled in
// byte order and returned on a valid/ready response channel.
//
// Optional feature macro: RAMSTEER_RANGECHECK_EN
//   defined   : accesses outside 0x4000-2^ADDRBITS..0x3fff are rejected
//               (rsp_err_o=1, rsp_rdata_o=0xFFFF, no bank activity).
//   undefined : no check; the upper address bits are ignored and every
//               address aliases into the RAM window. rsp_err_o stays 0.
//
// Ports:
//   clk_i, reset_i             clock, async active-high reset
//   req_*_i / req_ready_o      request channel (addr, write, wide, wdata)
//   rsp_*_o / rsp_ready_i      response channel (rdata, err)
//   read_addr_*_o              bank read addresses (data returns next cycle)
//   read_data_*_i              bank read data
//   write_addr/data/en_*_o     bank write ports
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | ready for a request; request fields captured on accept
// ISSUE    | bank addresses driven; write strobes high for this cycle
// CAPTURE  | bank read data valid, latched into the response register
// RESP     | response held until rsp_ready_i
module ram_port_steer #(
  parameter int ADDRBITS = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [14:0] req_addr_i,
  input  logic        req_write_i,
  input  logic        req_wide_i,
  input  logic [15:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [14:0] read_addr_even_o,
  output logic [14:0] read_addr_odd_o,
  input  logic [7:0]  read_data_even_i,
  input  logic [7:0]  read_data_odd_i,
  output logic [14:0] write_addr_even_o,
  output logic [14:0] write_addr_odd_o,
  output logic [7:0]  write_data_even_o,
  output logic [7:0]  write_data_odd_o,
  output logic        write_en_even_o,
  output logic        write_en_odd_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPTURE, ST_RESP} state_e;

  localparam logic [15:0] RAM_BYTES = 16'd1 << ADDRBITS;
  localparam logic [14:0] WIN_LO    = 15'(16'h4000 - RAM_BYTES);

  state_e state_q, state_d;

  logic        wide_q, odd_q, write_q;
  logic        rsp_err_q;
  logic [15:0] rsp_rdata_q;
  logic [14:0] read_addr_even_q, read_addr_odd_q;
  logic [14:0] write_addr_even_q, write_addr_odd_q;
  logic [7:0]  write_data_even_q, write_data_odd_q;
  logic        write_en_even_q, write_en_odd_q;

  logic [14:0] a0, a1, ea0, ea1, even_addr, odd_addr;
  logic [7:0]  even_wdata, odd_wdata;
  logic        use_even, use_odd, reject, accept;

`ifdef RAMSTEER_RANGECHECK_EN
  localparam logic [14:0] WIN_HI = 15'h3fff;

  function automatic logic in_window(input logic [14:0] a);
    return (a >= WIN_LO) && (a <= WIN_HI);
  endfunction
`else
  localparam logic [14:0] AMASK = 15'(RAM_BYTES - 16'd1);
`endif

  // Request decode, used only on the accept edge.
  always_comb begin
    a0 = req_addr_i;
    a1 = req_addr_i + 15'd1;   // wraps 0x7fff -> 0x0000
`ifdef RAMSTEER_RANGECHECK_EN
    ea0    = a0;
    ea1    = a1;
    reject = !in_window(a0) || (req_wide_i && !in_window(a1));
`else
    // Fold any address onto the window so the bank sees an in-range address.
    ea0    = (a0 & AMASK) | WIN_LO;
    ea1    = (a1 & AMASK) | WIN_LO;
    reject = 1'b0;
`endif
    even_addr  = a0[0] ? ea1 : ea0;
    odd_addr   = a0[0] ? ea0 : ea1;
    even_wdata = a0[0] ? req_wdata_i[15:8] : req_wdata_i[7:0];
    odd_wdata  = a0[0] ? req_wdata_i[7:0]  : req_wdata_i[15:8];
    use_even   = !a0[0] || req_wide_i;
    use_odd    = a0[0]  || req_wide_i;
    accept     = (state_q == ST_IDLE) && req_valid_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_valid_i) state_d = reject ? ST_RESP : ST_ISSUE;
      ST_ISSUE:   state_d = write_q ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    if (rsp_ready_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == ST_IDLE);
    rsp_valid_o = (state_q == ST_RESP);
  end

  // Bank ports are registered on the accept edge so they are valid for the
  // whole ISSUE cycle; lanes not used by an access keep their last value.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wide_q            <= 1'b0;
      odd_q             <= 1'b0;
      write_q           <= 1'b0;
      rsp_err_q         <= 1'b0;
      rsp_rdata_q       <= '0;
      read_addr_even_q  <= '0;
      read_addr_odd_q   <= '0;
      write_addr_even_q <= '0;
      write_addr_odd_q  <= '0;
      write_data_even_q <= '0;
      write_data_odd_q  <= '0;
      write_en_even_q   <= 1'b0;
      write_en_odd_q    <= 1'b0;
    end else begin
      write_en_even_q <= 1'b0;
      write_en_odd_q  <= 1'b0;
      if (accept) begin
        wide_q  <= req_wide_i;
        odd_q   <= a0[0];
        write_q <= req_write_i;
        if (reject) begin
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= 16'hFFFF;
        end else begin
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          if (req_write_i) begin
            if (use_even) begin
              write_addr_even_q <= even_addr;
              write_data_even_q <= even_wdata;
              write_en_even_q   <= 1'b1;
            end
            if (use_odd) begin
              write_addr_odd_q <= odd_addr;
              write_data_odd_q <= odd_wdata;
              write_en_odd_q   <= 1'b1;
            end
          end else begin
            if (use_even) read_addr_even_q <= even_addr;
            if (use_odd)  read_addr_odd_q  <= odd_addr;
          end
        end
      end else if (state_q == ST_CAPTURE) begin
        rsp_rdata_q[7:0]  <= odd_q ? read_data_odd_i : read_data_even_i;
        rsp_rdata_q[15:8] <= !wide_q ? 8'h00 :
                             (odd_q ? read_data_even_i : read_data_odd_i);
      end
    end
  end

  assign rsp_rdata_o       = rsp_rdata_q;
  assign rsp_err_o         = rsp_err_q;
  assign read_addr_even_o  = read_addr_even_q;
  assign read_addr_odd_o   = read_addr_odd_q;
  assign write_addr_even_o = write_addr_even_q;
  assign write_addr_odd_o  = write_addr_odd_q;
  assign write_data_even_o = write_data_even_q;
  assign write_data_odd_o  = write_data_odd_q;
  assign write_en_even_o   = write_en_even_q;
  assign write_en_odd_o    = write_en_odd_q;

endmodule

// File: tb/tb_ram_port_steer.sv
module tb_ram_port_steer;

  localparam int AB       = 10;
  localparam int WIN_LO_I = 16384 - (1 << AB);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [14:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic        req_wide = 1'b0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [14:0] read_addr_even, read_addr_odd;
  logic [7:0]  read_data_even = '0, read_data_odd = '0;
  logic [14:0] write_addr_even, write_addr_odd;
  logic [7:0]  write_data_even, write_data_odd;
  logic        write_en_even, write_en_odd;

  int checks = 0;
  int errors = 0;

  ram_port_steer #(.ADDRBITS(AB)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_write_i(req_write), .req_wide_i(req_wide),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .read_addr_even_o(read_addr_even), .read_addr_odd_o(read_addr_odd),
    .read_data_even_i(read_data_even), .read_data_odd_i(read_data_odd),
    .write_addr_even_o(write_addr_even), .write_addr_odd_o(write_addr_odd),
    .write_data_even_o(write_data_even), .write_data_odd_o(write_data_odd),
    .write_en_even_o(write_en_even), .write_en_odd_o(write_en_odd)
  );

  always #5 clk = ~clk;

  // Banked RAM model, byte addressed by the full bank address.
  bit [7:0] ram [0:32767];
  always @(posedge clk) begin
    if (write_en_even) ram[write_addr_even] <= write_data_even;
    if (write_en_odd)  ram[write_addr_odd]  <= write_data_odd;
    read_data_even <= ram[read_addr_even];
    read_data_odd  <= ram[read_addr_odd];
  end

  int cnt_e = 0, cnt_o = 0;
  always @(negedge clk) begin
    if (write_en_even) cnt_e <= cnt_e + 1;
    if (write_en_odd)  cnt_o <= cnt_o + 1;
  end

  // Reference memory as the CPU sees it.
  bit [7:0] ref_mem [0:32767];

  function automatic int alias_a(input int a);
`ifdef RAMSTEER_RANGECHECK_EN
    return a;
`else
    return WIN_LO_I + (a % (1 << AB));
`endif
  endfunction

  function automatic bit in_win(input int a);
    return (a >= WIN_LO_I) && (a < 16384);
  endfunction

  function automatic bit rejected(input int a, input bit wide);
`ifdef RAMSTEER_RANGECHECK_EN
    return !in_win(a) || (wide && !in_win((a + 1) % 32768));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] exp_read(input int a, input bit wide);
    logic [15:0] r;
    r[7:0]  = ref_mem[alias_a(a)];
    r[15:8] = wide ? ref_mem[alias_a((a + 1) % 32768)] : 8'h00;
    return r;
  endfunction

  task automatic model_write(input int a, input bit wide, input logic [15:0] wd);
    ref_mem[alias_a(a)] = wd[7:0];
    if (wide) ref_mem[alias_a((a + 1) % 32768)] = wd[15:8];
  endtask

  // Snapshot of bank ports in the cycle after acceptance.
  logic        t1_we_e, t1_we_o;
  logic [14:0] t1_wa_e, t1_wa_o;
  logic [7:0]  t1_wd_e, t1_wd_o;
  logic        post_rr, post_rv;

  // Runs one access starting at posedge+1; returns response, latency in
  // cycles after acceptance, and strobe counts seen during the access.
  task automatic do_access(input int addr, input bit wr, input bit wide,
                           input logic [15:0] wd, output logic [15:0] rd,
                           output logic er, output int lat,
                           output int pe, output int po);
    int se, so;
    se = cnt_e; so = cnt_o;
    req_valid = 1'b1; req_addr = 15'(addr); req_write = wr;
    req_wide = wide; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    t1_we_e = write_en_even; t1_we_o = write_en_odd;
    t1_wa_e = write_addr_even; t1_wa_o = write_addr_odd;
    t1_wd_e = write_data_even; t1_wd_o = write_data_odd;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 20) begin
      errors++;
      $display("FAIL response_timeout addr=%h got no rsp_valid, required within 3 cycles", addr);
    end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    post_rr = req_ready; post_rv = rsp_valid;
    pe = cnt_e - se; po = cnt_o - so;
  endtask

  task automatic test_reset;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, write_en_even, write_en_odd} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl got rr/rv/err/we_e/we_o=%b required 10000",
               {req_ready, rsp_valid, rsp_err, write_en_even, write_en_odd});
    end
    checks++;
    if ({rsp_rdata, read_addr_even, read_addr_odd, write_addr_even, write_addr_odd} !== '0) begin
      errors++;
      $display("FAIL reset_data got rdata=%h ra_e=%h ra_o=%h wa_e=%h wa_o=%h required all 0",
               rsp_rdata, read_addr_even, read_addr_odd, write_addr_even, write_addr_odd);
    end
  endtask

  task automatic test_narrow;
    logic [15:0] rd; logic er; int lat, pe, po;
    do_access(16'h3c01, 1'b1, 1'b0, 16'h005A, rd, er, lat, pe, po);
    model_write(16'h3c01, 1'b0, 16'h005A);
    checks++;
    if (lat !== 2 || rd !== 16'h0000) begin
      errors++; $display("FAIL narrow_wr_resp got lat=%0d rdata=%h required 2/0000", lat, rd);
    end
    checks++;
    if (t1_we_o !== 1'b1 || t1_we_e !== 1'b0 || t1_wa_o !== 15'h3c01 || t1_wd_o !== 8'h5A) begin
      errors++; $display("FAIL narrow_wr_t1 got we_o=%b we_e=%b wa_o=%h wd_o=%h required 1/0/3c01/5a",
                         t1_we_o, t1_we_e, t1_wa_o, t1_wd_o);
    end
    checks++;
    if (pe !== 0 || po !== 1) begin
      errors++; $display("FAIL narrow_wr_pulses got even=%0d odd=%0d required 0/1", pe, po);
    end
    do_access(16'h3c01, 1'b0, 1'b0, 16'h0, rd, er, lat, pe, po);
    checks++;
    if (lat !== 3 || rd !== 16'h005A || er !== 1'b0) begin
      errors++; $display("FAIL narrow_rd got lat=%0d rdata=%h err=%b required 3/005a/0", lat, rd, er);
    end
    checks++;
    if (post_rr !== 1'b1 || post_rv !== 1'b0) begin
      errors++; $display("FAIL narrow_rd_after got rr=%b rv=%b required 1/0", post_rr, post_rv);
    end
  endtask

  task automatic test_wide;
    logic [15:0] rd; logic er; int lat, pe, po;
    do_access(16'h3c01, 1'b1, 1'b1, 16'hBEEF, rd, er, lat, pe, po);
    model_write(16'h3c01, 1'b1, 16'hBEEF);
    checks++;
    if (t1_wa_o !== 15'h3c01 || t1_wd_o !== 8'hEF || t1_wa_e !== 15'h3c02 || t1_wd_e !== 8'hBE
        || t1_we_e !== 1'b1 || t1_we_o !== 1'b1) begin
      errors++; $display("FAIL wide_wr_lanes got odd %h:%h even %h:%h required 3c01:ef 3c02:be",
                         t1_wa_o, t1_wd_o, t1_wa_e, t1_wd_e);
    end
    checks++;
    if (pe !== 1 || po !== 1 || lat !== 2) begin
      errors++; $display("FAIL wide_wr_pulses got even=%0d odd=%0d lat=%0d required 1/1/2", pe, po, lat);
    end
    do_access(16'h3c01, 1'b0, 1'b1, 16'h0, rd, er, lat, pe, po);
    checks++;
    if (lat !== 3 || rd !== 16'hBEEF) begin
      errors++; $display("FAIL wide_rd got lat=%0d rdata=%h required 3/beef", lat, rd);
    end
  endtask

  task automatic test_edge;
    logic [15:0] rd; logic er; int lat, pe, po;
    do_access(16'h3fff, 1'b1, 1'b0, 16'h0011, rd, er, lat, pe, po);
    model_write(16'h3fff, 1'b0, 16'h0011);
    do_access(16'h3c00, 1'b1, 1'b0, 16'h0022, rd, er, lat, pe, po);
    model_write(16'h3c00, 1'b0, 16'h0022);
    for (int k = 0; k < 2; k++) begin
      int a;
      a = (k == 0) ? 16'h3fff : 16'h7fff;
      do_access(a, 1'b0, 1'b1, 16'h0, rd, er, lat, pe, po);
`ifdef RAMSTEER_RANGECHECK_EN
      checks++;
      if (er !== 1'b1 || rd !== 16'hFFFF || lat !== 1) begin
        errors++; $display("FAIL edge_reject a=%h got err=%b rdata=%h lat=%0d required 1/ffff/1", a, er, rd, lat);
      end
`else
      checks++;
      if (er !== 1'b0 || rd !== 16'h2211 || lat !== 3) begin
        errors++; $display("FAIL edge_alias a=%h got err=%b rdata=%h lat=%0d required 0/2211/3", a, er, rd, lat);
      end
`endif
      checks++;
      if (pe !== 0 || po !== 0) begin
        errors++; $display("FAIL edge_no_strobe a=%h got even=%0d odd=%0d required 0/0", a, pe, po);
      end
    end
`ifdef RAMSTEER_RANGECHECK_EN
    do_access(16'h3fff, 1'b1, 1'b1, 16'h5566, rd, er, lat, pe, po);
    checks++;
    if (er !== 1'b1 || pe !== 0 || po !== 0) begin
      errors++; $display("FAIL edge_wr_reject got err=%b even=%0d odd=%0d required 1/0/0", er, pe, po);
    end
`endif
  endtask

  task automatic test_backpressure;
    int n;
    req_valid = 1'b1; req_addr = 15'h3c01; req_write = 1'b0; req_wide = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL bp_latency got %0d required 3", n);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hBEEF || req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle=%0d got rv=%b rdata=%h rr=%b required 1/beef/0",
                           i, rsp_valid, rsp_rdata, req_ready);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got rv=%b rr=%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_write;
    logic [15:0] rd; logic er; int lat, pe, po;
    do_access(16'h3c10, 1'b1, 1'b0, 16'h0033, rd, er, lat, pe, po);
    model_write(16'h3c10, 1'b0, 16'h0033);
    req_valid = 1'b1; req_addr = 15'h3c10; req_write = 1'b1; req_wide = 1'b0;
    req_wdata = 16'h0099;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (write_en_even !== 1'b1) begin
      errors++; $display("FAIL rst_issue_strobe got %b required 1", write_en_even);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (write_en_even !== 1'b0 || write_en_odd !== 1'b0) begin
      errors++; $display("FAIL rst_strobe_drop got even=%b odd=%b required 0/0", write_en_even, write_en_odd);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_release got rr=%b rv=%b required 1/0", req_ready, rsp_valid);
    end
    do_access(16'h3c10, 1'b0, 1'b0, 16'h0, rd, er, lat, pe, po);
    checks++;
    if (rd !== 16'h0033) begin
      errors++; $display("FAIL rst_mem_unchanged got %h required 0033", rd);
    end
  endtask

  task automatic test_random;
    logic [15:0] rd, wd, erd; logic er; int lat, pe, po, a, sel, elat;
    bit wr, wide, rej, ee, eo;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(3);
      if (sel < 2)       a = WIN_LO_I + $urandom_range((1 << AB) - 1);
      else if (sel == 2) a = ($urandom_range(1)) ? 16383 - $urandom_range(2) : WIN_LO_I - 1 + $urandom_range(2);
      else               a = $urandom_range(32767);
      wr   = 1'($urandom_range(1));
      wide = 1'($urandom_range(1));
      wd   = 16'($urandom);
      rej  = rejected(a, wide);
      elat = rej ? 1 : (wr ? 2 : 3);
      erd  = rej ? 16'hFFFF : (wr ? 16'h0000 : exp_read(a, wide));
      ee   = !rej && wr && ((a % 2 == 0) || wide);
      eo   = !rej && wr && ((a % 2 == 1) || wide);
      do_access(a, wr, wide, wd, rd, er, lat, pe, po);
      if (!rej && wr) model_write(a, wide, wd);
      checks++;
      if (lat !== elat || rd !== erd || er !== rej) begin
        errors++; $display("FAIL rand_rsp i=%0d a=%h wr=%b wide=%b got lat=%0d rdata=%h err=%b required %0d/%h/%b",
                           i, a, wr, wide, lat, rd, er, elat, erd, rej);
      end
      checks++;
      if (pe !== int'(ee) || po !== int'(eo)) begin
        errors++; $display("FAIL rand_strobes i=%0d a=%h got even=%0d odd=%0d required %0d/%0d",
                           i, a, pe, po, ee, eo);
      end
      checks++;
      if (post_rr !== 1'b1 || post_rv !== 1'b0) begin
        errors++; $display("FAIL rand_after i=%0d got rr=%b rv=%b required 1/0", i, post_rr, post_rv);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b0;
    @(posedge clk); #1;
    test_narrow;
    test_wide;
    test_edge;
    test_backpressure;
    test_reset_mid_write;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
